// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared MMIO map and STATUS bit layout for the data-memory responder
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [27:0] MMIO_BASE_HI = 28'h400_0000;

  localparam logic [3:0] OFF_GPIO   = 4'h0;
  localparam logic [3:0] OFF_CYCLES = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_TXDATA = 4'hC;

  localparam int STAT_BUSERR  = 0;
  localparam int STAT_TXOVF   = 1;
  localparam int STAT_OCC_LSB = 2;

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo
// Purpose  : In-order console byte FIFO; full-with-pop accepts the push
// Revision : 1.0
// ============================================================================
module tx_fifo #(
  parameter int TX_DEPTH = 4,
  parameter int AW       = $clog2(TX_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]  mem_q [TX_DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        push_ok;
  logic        pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (count_o == (AW+1)'(TX_DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : CPU data-port responder: byte-writable RAM, GPIO, cycle counter,
//            sticky status and a console TX FIFO behind a small MMIO window
// Revision : 1.0
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int TX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [31:0] gpio_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int          RAM_AW    = $clog2(DEPTH_WORDS);
  localparam int          CNT_W     = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) * 32'd4;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [31:0]       gpio_q, gpio_d;
  logic [31:0]       cycles_q, cycles_d;
  logic              buserr_q, buserr_d;
  logic              txovf_q, txovf_d;
  logic              is_ram, is_mmio, any_we;
  logic [3:0]        reg_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              push_req, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       status_word;
  logic              unused_addr;

  assign is_ram      = (daddr < RAM_BYTES);
  assign is_mmio     = (daddr[31:4] == MMIO_BASE_HI);
  assign any_we      = |dwe;
  assign reg_off     = {daddr[3:2], 2'b00};
  assign ram_idx     = daddr[RAM_AW+1:2];
  assign unused_addr = ^daddr[1:0];

  assign push_req = reset && is_mmio && (reg_off == OFF_TXDATA) && dwe[0];
  assign pop      = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;
  assign gpio_out = gpio_q;

  tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (dwdata[7:0]),
    .dout_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status_word               = '0;
    status_word[STAT_BUSERR]  = buserr_q;
    status_word[STAT_TXOVF]   = txovf_q;
    status_word[STAT_OCC_LSB +: CNT_W] = fifo_count;
  end

  always_comb begin
    gpio_d   = gpio_q;
    cycles_d = cycles_q + 32'd1;
    buserr_d = buserr_q;
    txovf_d  = txovf_q;
    if (is_mmio && reg_off == OFF_GPIO) begin
      for (int i = 0; i < 4; i++)
        if (dwe[i]) gpio_d[8*i +: 8] = dwdata[8*i +: 8];
    end
    if (is_mmio && reg_off == OFF_CYCLES && any_we) cycles_d = '0;
    if (is_mmio && reg_off == OFF_STATUS && dwe[0]) begin
      if (dwdata[STAT_BUSERR]) buserr_d = 1'b0;
      if (dwdata[STAT_TXOVF])  txovf_d  = 1'b0;
    end
    // Set events are applied last so they win over a same-cycle clear.
    if (!is_ram && !is_mmio && any_we)      buserr_d = 1'b1;
    if (push_req && fifo_full && !pop)      txovf_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q   <= '0;
      cycles_q <= '0;
      buserr_q <= 1'b0;
      txovf_q  <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      cycles_q <= cycles_d;
      buserr_q <= buserr_d;
      txovf_q  <= txovf_d;
    end
  end

  // RAM is deliberately not reset; writes are held off while reset is low.
  always_ff @(posedge clk) begin
    if (reset && is_ram) begin
      for (int i = 0; i < 4; i++)
        if (dwe[i]) mem_q[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
    end
  end

  always_comb begin
    drdata = '0;
    if (!reset) begin
      drdata = '0;
    end else if (is_ram) begin
      drdata = mem_q[ram_idx];
    end else if (is_mmio) begin
      case (reg_off)
        OFF_GPIO:   drdata = gpio_q;
        OFF_CYCLES: drdata = cycles_q;
        OFF_STATUS: drdata = status_word;
        default:    drdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

  localparam logic [31:0] A_GPIO   = 32'h4000_0000;
  localparam logic [31:0] A_CYCLES = 32'h4000_0004;
  localparam logic [31:0] A_STATUS = 32'h4000_0008;
  localparam logic [31:0] A_TXDATA = 32'h4000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [31:0] gpio_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .TX_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .drdata   (drdata),
    .gpio_out (gpio_out),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    daddr  = a;
    dwdata = d;
    dwe    = we;
    tick();
    dwe    = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; daddr = A_GPIO; dwdata = '0; dwe = 4'h0; tx_ready = 1'b0;
    #3;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL reset_drdata: got %h want %h", drdata, 32'h0); end
    checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL reset_gpio: got %h want %h", gpio_out, 32'h0); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    tick(); tick();
    daddr = A_CYCLES;
    reset = 1'b1;
    #1;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL cycles_start: got %h want %h", drdata, 32'h0); end
    tick();
    checks++; if (drdata !== 32'h1) begin failures++; $display("FAIL cycles_first_edge: got %h want %h", drdata, 32'h1); end
  endtask

  task automatic test_ram_bytes();
    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    daddr = 32'h10; #1;
    checks++; if (drdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_full_word: got %h want %h", drdata, 32'hDEADBEEF); end
    dwdata = 32'h0000_5500; dwe = 4'h2; #1;
    checks++; if (drdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_read_during_write: got %h want %h", drdata, 32'hDEADBEEF); end
    tick(); dwe = 4'h0; #1;
    checks++; if (drdata !== 32'hDEAD_55EF) begin failures++; $display("FAIL ram_lane_merge: got %h want %h", drdata, 32'hDEAD55EF); end
    daddr = 32'h13; #1;
    checks++; if (drdata !== 32'hDEAD_55EF) begin failures++; $display("FAIL ram_low_bits_ignored: got %h want %h", drdata, 32'hDEAD55EF); end
  endtask

  task automatic test_gpio();
    wr(A_GPIO, 32'h1234_5678, 4'hF);
    checks++; if (gpio_out !== 32'h1234_5678) begin failures++; $display("FAIL gpio_out: got %h want %h", gpio_out, 32'h12345678); end
    wr(A_GPIO, 32'hAB00_0000, 4'h8);
    daddr = A_GPIO; #1;
    checks++; if (gpio_out !== 32'hAB34_5678) begin failures++; $display("FAIL gpio_lane: got %h want %h", gpio_out, 32'hAB345678); end
    checks++; if (drdata !== 32'hAB34_5678) begin failures++; $display("FAIL gpio_readback: got %h want %h", drdata, 32'hAB345678); end
  endtask

  task automatic test_cycles();
    wr(A_CYCLES, 32'h0, 4'hF);
    daddr = A_CYCLES; #1;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL cycles_cleared: got %h want %h", drdata, 32'h0); end
    tick();
    checks++; if (drdata !== 32'h1) begin failures++; $display("FAIL cycles_n_plus_2: got %h want %h", drdata, 32'h1); end
    tick();
    checks++; if (drdata !== 32'h2) begin failures++; $display("FAIL cycles_n_plus_3: got %h want %h", drdata, 32'h2); end
    force dut.cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycles_q;
    #1;
    tick();
    checks++; if (drdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cycles_max: got %h want %h", drdata, 32'hFFFFFFFF); end
    tick();
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL cycles_wrap: got %h want %h", drdata, 32'h0); end
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(A_TXDATA, 32'h41 + 32'(i), 4'h1);
    daddr = A_STATUS; #1;
    checks++; if (drdata !== 32'h12) begin failures++; $display("FAIL ovf_status: got %h want %h", drdata, 32'h12); end
    daddr = A_TXDATA; #1;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL txdata_read_zero: got %h want %h", drdata, 32'h0); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        failures++; $display("FAIL drain_order[%0d]: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
    daddr = A_STATUS; #1;
    checks++; if (drdata !== 32'h2) begin failures++; $display("FAIL ovf_sticky: got %h want %h", drdata, 32'h2); end
    wr(A_STATUS, 32'h2, 4'h1);
    daddr = A_STATUS; #1;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL ovf_clear: got %h want %h", drdata, 32'h0); end
  endtask

  task automatic test_buserr();
    wr(32'h0, 32'hCAFE_F00D, 4'hF);
    wr(32'h2000_0000, 32'h1, 4'hF);
    daddr = 32'h2000_0000; #1;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h want %h", drdata, 32'h0); end
    daddr = A_STATUS; #1;
    checks++; if (drdata !== 32'h1) begin failures++; $display("FAIL buserr_set: got %h want %h", drdata, 32'h1); end
    daddr = 32'h0; #1;
    checks++; if (drdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL buserr_ram0_kept: got %h want %h", drdata, 32'hCAFEF00D); end
    daddr = 32'h10; #1;
    checks++; if (drdata !== 32'hDEAD_55EF) begin failures++; $display("FAIL buserr_ram10_kept: got %h want %h", drdata, 32'hDEAD55EF); end
    wr(A_STATUS, 32'h0, 4'h1);
    daddr = A_STATUS; #1;
    checks++; if (drdata !== 32'h1) begin failures++; $display("FAIL buserr_write0_keeps: got %h want %h", drdata, 32'h1); end
    wr(A_STATUS, 32'h1, 4'h1);
    daddr = A_STATUS; #1;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL buserr_clear: got %h want %h", drdata, 32'h0); end
  endtask

  task automatic test_full_push_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'h61 + 32'(i), 4'h1);
    daddr = A_STATUS; #1;
    checks++; if (drdata !== 32'h10) begin failures++; $display("FAIL full_status: got %h want %h", drdata, 32'h10); end
    daddr = A_TXDATA; dwdata = 32'h65; dwe = 4'h1; tx_ready = 1'b1; #1;
    checks++; if (tx_data !== 8'h61) begin failures++; $display("FAIL full_head: got %h want 61", tx_data); end
    tick();
    dwe = 4'h0; tx_ready = 1'b0; daddr = A_STATUS; #1;
    checks++; if (drdata !== 32'h10) begin failures++; $display("FAIL full_pushpop_status: got %h want %h", drdata, 32'h10); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h62 + i)) begin
        failures++; $display("FAIL full_drain[%0d]: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, 8'(8'h62 + i));
      end
      tick();
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_drain();
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h71 + 32'(i), 4'h1);
    tx_ready = 1'b1; daddr = A_STATUS; #1;
    checks++; if (tx_valid !== 1'b1 || gpio_out !== 32'hAB34_5678) begin
      failures++; $display("FAIL pre_reset_state: got valid=%b gpio=%h want valid=1 gpio=ab345678", tx_valid, gpio_out);
    end
    reset = 1'b0; #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL async_reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL async_reset_drdata: got %h want %h", drdata, 32'h0); end
    tick();
    reset = 1'b1; tx_ready = 1'b0; #1;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL post_reset_status: got %h want %h", drdata, 32'h0); end
    checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL post_reset_gpio: got %h want %h", gpio_out, 32'h0); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL post_reset_tx_valid: got %b want 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_ram_bytes();
    test_gpio();
    test_cycles();
    test_fifo_overflow();
    test_buserr();
    test_full_push_pop();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
